// File: rtl/nanci_pkg.sv
// Shared definitions for the mesh loader: FSM state encoding and word-width helper.
package nanci_pkg;

   typedef enum logic [1:0] {
      StFill   = 2'b00,
      StCommit = 2'b01,
      StStart  = 2'b10,
      StWait   = 2'b11
   } state_e;

   // Host word is {key, payload}, each one PE index wide.
   function automatic int unsigned word_width(input int unsigned addr_width);
      return 2 * addr_width;
   endfunction

endpackage

// File: rtl/mesh_row_buffer.sv
// One mesh row of W-bit slots: indexed single-slot write, all slots read in parallel.
module mesh_row_buffer #(
   parameter int unsigned SLOTS = 32,
   parameter int unsigned W     = 20,
   parameter int unsigned AW    = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we_i,
   input  logic [AW-1:0]        waddr_i,
   input  logic [W-1:0]         wdata_i,
   output logic [SLOTS*W-1:0]   rdata_o
);

   logic [W-1:0] mem_q [SLOTS];

   // Slots are never cleared between rows; each is only overwritten in place.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < SLOTS; k++) begin
            mem_q[k] <= '0;
         end
      end else if (we_i) begin
         for (int k = 0; k < SLOTS; k++) begin
            if (waddr_i == AW'(k)) begin
               mem_q[k] <= wdata_i;
            end
         end
      end
   end

   for (genvar g = 0; g < SLOTS; g++) begin : g_rd
      assign rdata_o[g*W +: W] = mem_q[g];
   end

endmodule

// File: rtl/mesh_loader.sv
// Streams host words into the PE mesh one row at a time, then kicks off the sort
// and waits for the mesh to report completion before accepting the next load.
module mesh_loader
   import nanci_pkg::*;
#(
   parameter int unsigned N          = 1024,
   parameter int unsigned SQRT_N     = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   localparam int unsigned W         = word_width(ADDR_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   input  logic [W-1:0]          s_data,
   output logic                  s_ready,
   output logic                  row_we,
   output logic [ADDR_WIDTH-1:0] row_sel,
   output logic [SQRT_N*W-1:0]   row_data,
   output logic                  mesh_start,
   input  logic                  mesh_done,
   output logic                  busy
);

   localparam int unsigned ROWS = N / SQRT_N;
   localparam logic [ADDR_WIDTH-1:0] LastCol = ADDR_WIDTH'(SQRT_N - 1);
   localparam logic [ADDR_WIDTH-1:0] LastRow = ADDR_WIDTH'(ROWS - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] col_cnt_q, col_cnt_d;
   logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
   logic                  accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StFill;
         col_cnt_q <= '0;
         row_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         row_cnt_q <= row_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      accept    = 1'b0;
      unique case (state_q)
         StFill: begin
            if (s_valid) begin
               accept = 1'b1;
               if (col_cnt_q == LastCol) begin
                  col_cnt_d = '0;
                  state_d   = StCommit;
               end else begin
                  col_cnt_d = col_cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         StCommit: begin
            if (row_cnt_q == LastRow) begin
               row_cnt_d = '0;
               state_d   = StStart;
            end else begin
               row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
               state_d   = StFill;
            end
         end
         StStart: state_d = StWait;
         StWait: begin
            if (mesh_done) begin
               state_d = StFill;
            end
         end
         default: state_d = StFill;
      endcase
   end

   // Outputs decode registered state only, so s_valid never reaches them combinationally.
   assign s_ready    = (state_q == StFill);
   assign row_we     = (state_q == StCommit);
   assign mesh_start = (state_q == StStart);
   assign busy       = (state_q != StFill);
   assign row_sel    = row_cnt_q;

   mesh_row_buffer #(
      .SLOTS (SQRT_N),
      .W     (W),
      .AW    (ADDR_WIDTH)
   ) u_row_buffer (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (accept),
      .waddr_i (col_cnt_q),
      .wdata_i (s_data),
      .rdata_o (row_data)
   );

endmodule

// File: doc/mesh_loader.md
MESH_LOADER -- requirements
Module: mesh_loader

Interface
REQ-001 SHALL have parameters, one per line:
- N, default 1024: total PEs.
- SQRT_N, default 32: mesh side length.
- ADDR_WIDTH, default 10: PE index width.
- Word width W = 2*ADDR_WIDTH.
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports, one per line:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  1  host word valid.
- s_data  in  W  packed {key, payload} word.
- s_ready  out  1  loader can accept a word.
- row_we  out  1  row-write strobe to mesh.
- row_sel  out  ADDR_WIDTH  target mesh row index.
- row_data  out  SQRT_N*W  row contents; slot k at bits [k*W +: W].
- mesh_start  out  1  one-cycle pulse that starts the PE sort sequence.
- mesh_done  in  1  PE array finished the compute phase.
- busy  out  1  high in every state except FILL.

Function
REQ-003 SHALL implement four states: FILL, COMMIT, START, WAIT.
REQ-004 FILL behaviour:
- s_ready=1.
- A transfer occurs when s_valid and s_ready are both high.
- Each transfer writes s_data to slot col_cnt and increments col_cnt.
REQ-005 When a transfer occurs at col_cnt==SQRT_N-1, SHALL clear col_cnt and go to COMMIT on the next edge.
REQ-006 COMMIT behaviour:
- Lasts exactly 1 cycle, with s_ready=0, row_we=1, row_sel=row_cnt.
- row_data holds all SQRT_N captured words, stable for the whole cycle.
REQ-007 Latency: last word of a row accepted at edge t -> row_we high during cycle t+1.
REQ-008 On leaving COMMIT:
- If row_cnt==SQRT_N-1: row_cnt wraps to 0 and the state goes to START.
- Otherwise: row_cnt increments and the state returns to FILL.
REQ-009 START SHALL last 1 cycle with mesh_start=1 and s_ready=0, then go to WAIT.
REQ-010 WAIT SHALL hold s_ready=0 until mesh_done is sampled high, then go to FILL.
REQ-011 mesh_done SHALL be ignored in FILL, COMMIT and START.
REQ-012 s_valid SHALL be ignored whenever s_ready=0:
- No slot write occurs.
- No counter change occurs.
REQ-013 s_valid low in FILL SHALL hold all counters and the buffer unchanged (stalls of any length allowed).
REQ-014 row_we and mesh_start SHALL never be high in the same cycle. Each SHALL be a single-cycle pulse.
REQ-015 Counters:
- col_cnt and row_cnt are ADDR_WIDTH bits.
- Their values never exceed SQRT_N-1.
REQ-016 Exactly N accepted words SHALL produce SQRT_N row_we pulses and one mesh_start pulse. Row order is 0..SQRT_N-1.
REQ-017 The row buffer SHALL retain the previous row's contents until overwritten slot by slot. No clearing between rows.

Reset
REQ-018 rst SHALL asynchronously force all of the following:
- state=FILL, col_cnt=0, row_cnt=0.
- row_we=0, mesh_start=0, row_sel=0, row_data=0, busy=0.
REQ-019 Reset asserted mid-row or mid-WAIT SHALL discard the partial load. No row_we or mesh_start after deassertion until a fresh row completes.
REQ-020 s_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-021 Package nanci_pkg SHALL hold:
- The state encoding (FILL=2'b00, COMMIT=2'b01, START=2'b10, WAIT=2'b11).
- The word-width constant expression W.
REQ-022 Sub-module mesh_row_buffer SHALL be used: an SQRT_N-slot W-bit register file with indexed write, flat parallel read and async reset.
REQ-023 All outputs SHALL be registered or decoded from registered state only. No combinational path from s_valid to any output.

Verification (SQRT_N=4, ADDR_WIDTH=4, N=16, W=8)
REQ-024 Reset, then 4 back-to-back words 0x11,0x22,0x33,0x44 -> row_we on the next cycle, row_sel=0, row_data=0x44332211, s_ready=0 during that cycle.
REQ-025 16 words streamed with s_valid continuously high -> row_we pulses for rows 0,1,2,3, mesh_start one cycle after the 4th row_we, then s_ready=0 until mesh_done.
REQ-026 Random s_valid gaps (50% duty) over 16 words -> identical row_data/row_sel sequence to REQ-025. s_valid during COMMIT/WAIT is not consumed.
REQ-027 mesh_done pulsed during FILL -> no state change. mesh_done pulsed in WAIT -> s_ready=1 next cycle and a second 16-word load starts again at row_sel=0.
REQ-028 rst asserted after 6 words -> outputs 0 immediately. Then 4 words 0xA1..0xA4 -> row_we with row_sel=0 and row_data=0xA4A3A2A1.
